// File: rtl/dram_arbiter_41464_if.sv
// Requester-side bundle for one port of the 41464 DRAM arbiter.
// The requester drives master; the arbiter consumes slave.
interface dram_arbiter_41464_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack
    );
endinterface

// File: rtl/dram_arbiter_41464.sv
// Arbiter and strobe sequencer for a 41464 DRAM bank.
// Refresh beats DMA beats CPU at every IDLE decision point.
module dram_arbiter_41464 #(
    parameter int DATA_W  = 16,
    parameter int T_RCD   = 2,
    parameter int T_CAS   = 2,
    parameter int T_RP    = 3,
    parameter int REF_INT = 110
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    dram_arbiter_41464_if.slave dma_if,
    dram_arbiter_41464_if.slave cpu_if,
    output logic [7:0]          dram_a_o,
    output logic                ras_n_o,
    output logic                cas_n_o,
    output logic                we_n_o,
    output logic                oe_n_o,
    output logic [DATA_W-1:0]   dq_o,
    output logic                dq_oe_o,
    input  logic [DATA_W-1:0]   dq_i,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int CW = 8;
    localparam int TW = $clog2(REF_INT);

    localparam logic [CW-1:0] RCD_LAST = CW'(T_RCD - 1);
    localparam logic [CW-1:0] CAS_LAST = CW'(T_CAS - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(T_RP - 1);
    localparam logic [CW-1:0] REF_LAST = CW'(T_RCD + T_CAS - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(REF_INT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RAS  = 3'd1;
    localparam logic [2:0] S_CAS  = 3'd2;
    localparam logic [2:0] S_PRE  = 3'd3;
    localparam logic [2:0] S_REF  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gnt_cpu_q, gnt_cpu_d;
    logic              acc_we_q, acc_we_d;
    logic [7:0]        col_q, col_d;
    logic              ras_n_q, ras_n_d;
    logic              cas_n_q, cas_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic [7:0]        dram_a_q, dram_a_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              dma_ack_q, dma_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [7:0]        ref_row_q, ref_row_d;
    logic              ref_pend_q, ref_pend_d;

    logic              sel_cpu;
    logic              sel_we;
    logic [15:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Port mux: DMA wins whenever it is requesting.
    always_comb begin
        sel_cpu   = !dma_if.req;
        sel_we    = sel_cpu ? cpu_if.we    : dma_if.we;
        sel_addr  = sel_cpu ? cpu_if.addr  : dma_if.addr;
        sel_wdata = sel_cpu ? cpu_if.wdata : dma_if.wdata;
    end

    // Next-state logic for the sequencer, refresh timer and outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_cpu_d  = gnt_cpu_q;
        acc_we_d   = acc_we_q;
        col_d      = col_q;
        ras_n_d    = ras_n_q;
        cas_n_d    = cas_n_q;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        dq_oe_d    = dq_oe_q;
        dq_d       = dq_q;
        dram_a_d   = dram_a_q;
        rdata_d    = rdata_q;
        dma_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        ref_row_d  = ref_row_q;
        ref_pend_d = ref_pend_q;
        tmr_d      = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ref_pend_q) begin
                    state_d    = S_REF;
                    dram_a_d   = ref_row_q;
                    ras_n_d    = 1'b0;
                    ref_row_d  = ref_row_q + 8'd1;
                    ref_pend_d = 1'b0;
                end else if (dma_if.req || cpu_if.req) begin
                    state_d   = S_RAS;
                    gnt_cpu_d = sel_cpu;
                    acc_we_d  = sel_we;
                    col_d     = sel_addr[7:0];
                    dram_a_d  = sel_addr[15:8];
                    dq_d      = sel_wdata;
                    ras_n_d   = 1'b0;
                    // Early write: _WE and the bus go active with _RAS.
                    we_n_d    = !sel_we;
                    dq_oe_d   = sel_we;
                end
            end
            S_RAS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RCD_LAST) begin
                    state_d  = S_CAS;
                    cnt_d    = '0;
                    dram_a_d = col_q;
                    cas_n_d  = 1'b0;
                    oe_n_d   = acc_we_q;
                end
            end
            S_CAS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CAS_LAST) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    if (!acc_we_q) begin
                        rdata_d = dq_i;
                    end
                    cpu_ack_d = gnt_cpu_q;
                    dma_ack_d = !gnt_cpu_q;
                    ras_n_d   = 1'b1;
                    cas_n_d   = 1'b1;
                    we_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    dq_oe_d   = 1'b0;
                end
            end
            S_REF: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == REF_LAST) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    ras_n_d = 1'b1;
                end
            end
            S_PRE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A timer wrap always leaves a refresh pending, even on a REF entry.
        if (tmr_q == TMR_LAST) begin
            ref_pend_d = 1'b1;
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            gnt_cpu_q  <= 1'b0;
            acc_we_q   <= 1'b0;
            col_q      <= '0;
            ras_n_q    <= 1'b1;
            cas_n_q    <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_q       <= '0;
            dram_a_q   <= '0;
            rdata_q    <= '0;
            dma_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            tmr_q      <= '0;
            ref_row_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_cpu_q  <= gnt_cpu_d;
            acc_we_q   <= acc_we_d;
            col_q      <= col_d;
            ras_n_q    <= ras_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            dq_oe_q    <= dq_oe_d;
            dq_q       <= dq_d;
            dram_a_q   <= dram_a_d;
            rdata_q    <= rdata_d;
            dma_ack_q  <= dma_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            tmr_q      <= tmr_d;
            ref_row_q  <= ref_row_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    assign dma_if.ack = dma_ack_q;
    assign cpu_if.ack = cpu_ack_q;
    assign dram_a_o   = dram_a_q;
    assign ras_n_o    = ras_n_q;
    assign cas_n_o    = cas_n_q;
    assign we_n_o     = we_n_q;
    assign oe_n_o     = oe_n_q;
    assign dq_o       = dq_q;
    assign dq_oe_o    = dq_oe_q;
    assign rdata_o    = rdata_q;
endmodule

// File: tb/tb_dram_arbiter_41464.sv
// Bench for dram_arbiter_41464: behavioural DRAM, scoreboard per port.
// Directed scenarios followed by randomized two-port traffic.
`timescale 1ns/1ps
module tb_dram_arbiter_41464;
    localparam int DW    = 16;
    localparam int REF   = 20;
    localparam int RCD   = 2;
    localparam int CASW  = 2;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_arbiter_41464_if #(.DATA_W(DW)) dma_if ();
    dram_arbiter_41464_if #(.DATA_W(DW)) cpu_if ();

    logic [7:0]    dram_a;
    logic          ras_n, cas_n, we_n, oe_n, dq_oe;
    logic [DW-1:0] dq_o, dq_i, rdata;

    dram_arbiter_41464 #(
        .DATA_W (DW),
        .T_RCD  (RCD),
        .T_CAS  (CASW),
        .T_RP   (3),
        .REF_INT(REF)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .dma_if  (dma_if),
        .cpu_if  (cpu_if),
        .dram_a_o(dram_a),
        .ras_n_o (ras_n),
        .cas_n_o (cas_n),
        .we_n_o  (we_n),
        .oe_n_o  (oe_n),
        .dq_o    (dq_o),
        .dq_oe_o (dq_oe),
        .dq_i    (dq_i),
        .rdata_o (rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Memory as seen through the pins, and the transaction-level model.
    logic [DW-1:0] dev_mem [65536];
    logic [DW-1:0] ref_mem [65536];
    txn_t q_dma[$];
    txn_t q_cpu[$];

    // Behavioural 41464 bank plus strobe-protocol checks.
    logic       pr_ras = 1'b1, pr_cas = 1'b1, pr_we = 1'b1, pr_dqoe = 1'b0;
    logic [7:0] row = '0, col = '0;
    logic [7:0] exp_row = '0;
    bit         cas_seen = 0, abort = 0, quiet = 0;
    int         ras_fall_cyc = 0, cas_fall_cyc = 0;
    int         last_ref_fall = -1, ref_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_row = '0;
            last_ref_fall = -1;
            abort = 1;
        end
        chk("cas_under_ras", {31'd0, !cas_n && ras_n}, 0);
        chk("we_and_oe", {31'd0, !we_n && !oe_n}, 0);
        if (oe_n) dq_i = 16'hDEAD;
        if (pr_ras && !ras_n) begin
            row = dram_a;
            ras_fall_cyc = cyc;
            cas_seen = 0;
            abort = !rst_n;
        end
        if (pr_cas && !cas_n) begin
            col = dram_a;
            cas_seen = 1;
            cas_fall_cyc = cyc;
            chk("t_rcd", cyc - ras_fall_cyc, RCD);
            if (!we_n) begin
                chk("early_write", {30'd0, pr_we, pr_dqoe}, 32'd1);
                chk("wr_oe_n", {31'd0, oe_n}, 1);
                dev_mem[{row, col}] = dq_o;
            end else begin
                chk("rd_strobes", {30'd0, oe_n, dq_oe}, 0);
                dq_i = dev_mem[{row, col}];
            end
        end
        if (!pr_cas && cas_n && !abort)
            chk("t_cas", cyc - cas_fall_cyc, CASW);
        if (!pr_ras && ras_n && !abort) begin
            chk("ras_width", cyc - ras_fall_cyc, RCD + CASW);
            if (!cas_seen) begin
                chk("ref_row", row, exp_row);
                exp_row = exp_row + 8'd1;
                ref_cnt++;
                if (quiet && last_ref_fall >= 0)
                    chk("ref_interval", ras_fall_cyc - last_ref_fall, REF);
                last_ref_fall = ras_fall_cyc;
            end
        end
        pr_ras = ras_n;
        pr_cas = cas_n;
        pr_we = we_n;
        pr_dqoe = dq_oe;
    end

    task automatic check_ack(input bit p);
        txn_t t;
        if (p ? (q_cpu.size() == 0) : (q_dma.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack port %0d at cycle %0d", p, cyc);
        end else begin
            t = p ? q_cpu.pop_front() : q_dma.pop_front();
            chk("ack_after_ras", cyc - ras_fall_cyc, RCD + CASW);
            if (t.we) ref_mem[t.addr] = t.wdata;
            else chk("rdata", rdata, ref_mem[t.addr]);
        end
    endtask

    // Scoreboard monitor: pops on every ACK the DUT presents.
    always @(negedge clk) begin
        chk("one_ack", {31'd0, dma_if.ack && cpu_if.ack}, 0);
        if (dma_if.ack) check_ack(0);
        if (cpu_if.ack) check_ack(1);
    end

    task automatic do_txn(input bit p, input bit we, input logic [15:0] addr,
                          input logic [DW-1:0] wd, output int lat);
        txn_t t;
        int   start;
        bit   got;
        t.we = we;
        t.addr = addr;
        t.wdata = wd;
        @(posedge clk);
        #1;
        if (p) begin
            cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wd;
            cpu_if.req = 1'b1;
            q_cpu.push_back(t);
        end else begin
            dma_if.we = we; dma_if.addr = addr; dma_if.wdata = wd;
            dma_if.req = 1'b1;
            q_dma.push_back(t);
        end
        start = cyc;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (p ? cpu_if.ack : dma_if.ack) got = 1;
        end
        lat = cyc - start;
        if (p) cpu_if.req = 1'b0;
        else dma_if.req = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout port %0d: got none expected ack", p);
            lat = -1;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [7:0] rows [4] = '{8'h00, 8'h5A, 8'hA5, 8'hFF};
    logic [7:0] cols [4] = '{8'h00, 8'h3C, 8'hC3, 8'hFF};

    initial begin
        int l1, l2, k, base;
        bit seen;
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = '0;
            ref_mem[i] = '0;
        end
        dma_if.req = 0; dma_if.we = 0; dma_if.addr = '0; dma_if.wdata = '0;
        cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;

        // 1: reset with both requests high
        @(posedge clk);
        #1 rst_n = 1'b0;
        dma_if.req = 1; cpu_if.req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {28'd0, ras_n, cas_n, we_n, oe_n}, 32'hF);
        chk("rst_dq_oe", {31'd0, dq_oe}, 0);
        chk("rst_acks", {30'd0, dma_if.ack, cpu_if.ack}, 0);
        chk("rst_dram_a", dram_a, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dq_o", dq_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dma_if.req = 0; cpu_if.req = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_ras", {31'd0, ras_n}, 1);
        end

        // 2: CPU read
        dev_mem[16'hA53C] = 16'h1234;
        ref_mem[16'hA53C] = 16'h1234;
        do_reset(2);
        do_txn(1, 0, 16'hA53C, '0, l1);
        chk("rd_latency", l1, 5);
        chk("rd_row", row, 8'hA5);
        chk("rd_col", col, 8'h3C);
        chk("rd_rdata", rdata, 16'h1234);

        // 3: DMA write
        do_reset(2);
        do_txn(0, 1, 16'h0102, 16'hBEEF, l1);
        chk("wr_latency", l1, 5);
        chk("wr_dq_o", dq_o, 16'hBEEF);
        chk("wr_mem", dev_mem[16'h0102], 16'hBEEF);

        // 4: contention
        do_reset(2);
        fork
            do_txn(0, 1, 16'h5AC3, 16'h7777, l1);
            do_txn(1, 0, 16'h0102, '0, l2);
        join
        chk("cont_dma_lat", l1, 5);
        chk("cont_cpu_lat", l2, 13);

        // 5: refresh cadence, row wrap, request during refresh
        do_reset(2);
        quiet = 1;
        base = ref_cnt;
        for (int i = 0; i < 258 * REF + 100 && ref_cnt - base < 258; i++)
            @(negedge clk);
        chk("ref_count", {31'd0, ref_cnt - base >= 258}, 1);
        seen = 0;
        for (int i = 0; i < 4 * REF && !seen; i++) begin
            @(negedge clk);
            if (!ras_n) seen = 1;
        end
        chk("ref_ras_seen", {31'd0, seen}, 1);
        quiet = 0;
        do_txn(1, 0, 16'hA53C, '0, l1);
        chk("ref_wait_lat", l1, 11);

        // 6: reset in the middle of CAS
        do_reset(2);
        @(posedge clk);
        #1 cpu_if.we = 0; cpu_if.addr = 16'hFFFF; cpu_if.req = 1;
        k = cyc;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        cpu_if.req = 0;
        @(negedge clk);
        chk("mid_cas_low", {31'd0, cas_n}, 0);
        chk("mid_cas_cycle", cyc - k, 3);
        @(negedge clk);
        chk("abort_strobes", {28'd0, ras_n, cas_n, we_n, oe_n}, 32'hF);
        chk("abort_dq_oe", {31'd0, dq_oe}, 0);
        chk("abort_acks", {30'd0, dma_if.ack, cpu_if.ack}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 7: randomized two-port traffic against the scoreboard
        do_reset(2);
        fork
            begin
                int lt;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(7, 0)) @(posedge clk);
                    do_txn(0, 1'($urandom_range(1, 0)),
                           {rows[$urandom_range(3, 0)], cols[$urandom_range(3, 0)]},
                           16'($urandom), lt);
                end
            end
            begin
                int lt;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(3, 0)) @(posedge clk);
                    do_txn(1, 1'($urandom_range(1, 0)),
                           {rows[$urandom_range(3, 0)], cols[$urandom_range(3, 0)]},
                           16'($urandom), lt);
                end
            end
        join
        repeat (12) @(negedge clk);
        chk("dma_q_empty", q_dma.size(), 0);
        chk("cpu_q_empty", q_cpu.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
